uart_rx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_rx_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and receiver FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_DEFAULT_CLKS_PER_BIT = 5208;
    localparam int c_DEFAULT_DATA_W       = 8;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_STOP    = 3'd3;
    localparam logic [2:0] c_ST_CLEANUP = 3'd4;
    localparam logic [2:0] c_ST_PARITY  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_START   = c_ST_START,
        ST_DATA    = c_ST_DATA,
        ST_STOP    = c_ST_STOP,
        ST_CLEANUP = c_ST_CLEANUP,
        ST_PARITY  = c_ST_PARITY
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with occupancy count; a push while full is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffer
//  Description : 8N1 UART receiver feeding a byte FIFO with valid/ack output.
//                Define UART_RX_PARITY_EN to add an even-parity bit check.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = c_DEFAULT_DATA_W,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_serial,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_valid,
    input  logic                          data_ack,
    output logic                          frame_error,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_error,
`endif
    output logic [2:0]                    state_out
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                 c_BIT_W     = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE   = c_BIT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx_s;
    uart_state_t        r_state;
    uart_state_t        w_state_nx;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [c_CNT_W-1:0] w_clk_cnt_nx;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt_nx;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nx;
    logic               r_frame_error;
    logic               w_frame_error_nx;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bit;
    logic               w_par_bit_nx;
    logic               r_parity_error;
    logic               w_parity_error_nx;
    logic               w_par_bad;
`endif

    // Two-flop synchroniser, preset to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_clk_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit      <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_clk_cnt      <= w_clk_cnt_nx;
            r_bit_cnt      <= w_bit_cnt_nx;
            r_shift        <= w_shift_nx;
            r_frame_error  <= w_frame_error_nx;
`ifdef UART_RX_PARITY_EN
            r_par_bit      <= w_par_bit_nx;
            r_parity_error <= w_parity_error_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx        = r_state;
        w_clk_cnt_nx      = r_clk_cnt;
        w_bit_cnt_nx      = r_bit_cnt;
        w_shift_nx        = r_shift;
        w_push            = 1'b0;
        w_frame_error_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_nx      = r_par_bit;
        w_parity_error_nx = 1'b0;
        w_par_bad         = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_nx = '0;
                w_bit_cnt_nx = '0;
                if (!w_rx_s) w_state_nx = ST_START;
            end
            ST_START: begin
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_cnt_nx = '0;
                    w_state_nx   = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + c_CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nx = '0;
                    w_shift_nx   = {w_rx_s, r_shift[DATA_W-1:1]};
                    if (r_bit_cnt == c_LAST_DATA) begin
                        w_bit_cnt_nx = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nx   = ST_PARITY;
`else
                        w_state_nx   = ST_STOP;
`endif
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + c_BIT_ONE;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + c_CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nx = '0;
                    w_par_bit_nx = w_rx_s;
                    w_state_nx   = ST_STOP;
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + c_CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nx     = '0;
                    w_state_nx       = ST_CLEANUP;
                    w_frame_error_nx = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                    // Even parity: data plus parity bit must XOR to zero.
                    w_par_bad         = ^{r_shift, r_par_bit};
                    w_parity_error_nx = w_par_bad;
                    w_push            = w_rx_s & ~w_par_bad;
`else
                    w_push            = w_rx_s;
`endif
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + c_CNT_ONE;
                end
            end
            ST_CLEANUP: w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    assign w_pop  = data_ack & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (data_out),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign data_valid  = ~w_empty;
    assign frame_error = r_frame_error;
    assign overflow    = r_overflow;
    assign state_out   = r_state;
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_parity_error;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_buffer
//  Description : Directed self-checking bench for uart_rx_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

    localparam int c_CPB = 8;

    logic       clk          = 1'b0;
    logic       reset        = 1'b0;
    logic       rx_serial    = 1'b1;
    logic       data_ack     = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       overflow;
    logic [2:0] fifo_count;
    logic [2:0] state_out;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int start_cnt = 0;
    logic       valid_pre;
    logic       valid_post;
    logic [2:0] count_post;
    int fe_snap;
    int pe_snap;
    int st_snap;

    always #5 clk = ~clk;

    uart_rx_buffer #(
        .CLKS_PER_BIT (c_CPB),
        .DATA_W       (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (rx_serial),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .frame_error  (frame_error),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .fifo_count   (fifo_count),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .state_out    (state_out)
    );

    // Pulse and state-visit counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_error) fe_cnt++;
        if (state_out == 3'd1) start_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a negedge; records data_valid just before and
    // just after the stop-bit sample, optionally acking across that sample edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input logic ack_at_push);
        rx_serial = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            repeat (c_CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_serial = (^d) ^ par_flip;
        repeat (c_CPB) @(negedge clk);
`else
        if (par_flip) rx_serial = 1'b1;
`endif
        rx_serial = stop_bit;
        for (int k = 1; k <= c_CPB; k++) begin
            @(negedge clk);
            if (k == 6) begin
                valid_pre = data_valid;
                rx_serial = 1'b1;
                if (ack_at_push) data_ack = 1'b1;
            end
            if (k == 7) begin
                valid_post = data_valid;
                count_post = fifo_count;
                data_ack   = 1'b0;
            end
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, data_valid, 1);
        chk({tag, "_data"}, data_out, exp);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_state", state_out, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single frame, latency and ack
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("t1_valid_pre", valid_pre, 0);
        chk("t1_valid_post", valid_post, 1);
        chk("t1_count_post", count_post, 1);
        chk("t1_data", data_out, 8'hA5);
        pop_chk("t1_pop", 8'hA5);
        chk("t1_count_after", fifo_count, 0);
        chk("t1_valid_after", data_valid, 0);

        // 2: short low glitch
        fe_snap = fe_cnt;
        st_snap = start_cnt;
        rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        chk("t2_saw_start", (start_cnt - st_snap) > 0, 1);
        chk("t2_state", state_out, 0);
        chk("t2_count", fifo_count, 0);
        chk("t2_ferr", fe_cnt - fe_snap, 0);

        // 3: bad stop bit
        fe_snap = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t3_ferr_cycles", fe_cnt - fe_snap, 1);
        chk("t3_count", fifo_count, 0);
        chk("t3_valid", data_valid, 0);

        // 4: overflow with five back-to-back frames
        fe_snap = fe_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        chk("t4_count", fifo_count, 4);
        chk("t4_ovf", overflow, 1);
        chk("t4_ferr", fe_cnt - fe_snap, 0);
        for (int i = 1; i <= 4; i++) pop_chk("t4_pop", 8'(i));
        chk("t4_count_empty", fifo_count, 0);
        chk("t4_ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("t4_ovf_clr", overflow, 0);

        // 5: push and pop together while full
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        chk("t5_count_full", fifo_count, 4);
        send_frame(8'h05, 1'b1, 1'b0, 1'b1);
        chk("t5_count_post", count_post, 4);
        chk("t5_count", fifo_count, 4);
        chk("t5_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) pop_chk("t5_pop", 8'(i));
        chk("t5_count_empty", fifo_count, 0);

        // 6: reset in the middle of a frame
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        chk("t6_count_pre", fifo_count, 2);
        rx_serial = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_serial = (i == 0) ? 1'b0 : 1'b1;
            repeat (c_CPB) @(negedge clk);
        end
        chk("t6_state_mid", state_out, 2);
        reset = 1'b0;
        rx_serial = 1'b1;
        #1;
        chk("t6_rst_valid", data_valid, 0);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_state", state_out, 0);
        chk("t6_rst_ferr", frame_error, 0);
        chk("t6_rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        chk("t6_count_new", fifo_count, 1);
        pop_chk("t6_pop", 8'h11);
`ifdef UART_RX_PARITY_EN
        pe_snap = pe_cnt;
        fe_snap = fe_cnt;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_perr", pe_cnt - pe_snap, 1);
        chk("t6_perr_ferr", fe_cnt - fe_snap, 0);
        chk("t6_perr_count", fifo_count, 0);
`else
        pe_snap = pe_cnt;
`endif
        chk("t6_count_end", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
